// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive GCD engine: FSM state encoding and default width.
package gcd_pkg;
    localparam int GCD_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FINISH  = 2'd2
    } gcd_state_e;
endpackage

// File: rtl/gcd_sub_engine_sub_borrow.sv
// Ripple-borrow subtractor: diff = a - b (mod 2^WIDTH), borrow set when b > a.
module sub_borrow #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    logic [WIDTH:0] bw;

    assign bw[0] = 1'b0;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign diff[gi]   = a[gi] ^ b[gi] ^ bw[gi];
        assign bw[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & bw[gi]);
    end

    assign borrow = bw[WIDTH];
endmodule

// File: rtl/gcd_sub_engine.sv
// Sequential GCD by repeated subtraction, one subtraction per clock, with start/done handshake,
// zero-operand error flag and a saturating subtraction counter.
module gcd_sub_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH  = GCD_WIDTH_DEFAULT,
    parameter int ITER_W = WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [ITER_W-1:0] iters,
    output logic              err
);
    localparam logic [ITER_W-1:0] CNT_MAX = '1;

    gcd_state_e        state_reg, state_next;
    logic [WIDTH-1:0]  ra_reg, ra_next;
    logic [WIDTH-1:0]  rb_reg, rb_next;
    logic [ITER_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0]  result_reg, result_next;
    logic [ITER_W-1:0] iters_reg, iters_next;
    logic              err_reg, err_next;
    logic              done_reg, done_next;

    logic [WIDTH-1:0]  diff_ab, diff_ba;
    logic              borrow_ab, borrow_ba;
    logic              stop_cond;
    logic [ITER_W-1:0] cnt_inc;

    sub_borrow #(.WIDTH(WIDTH)) u_sub_ab (
        .a      (ra_reg),
        .b      (rb_reg),
        .diff   (diff_ab),
        .borrow (borrow_ab)
    );

    sub_borrow #(.WIDTH(WIDTH)) u_sub_ba (
        .a      (rb_reg),
        .b      (ra_reg),
        .diff   (diff_ba),
        .borrow (borrow_ba)
    );

    // Zero difference means equal operands; either operand zero also ends the loop.
    assign stop_cond = (~|ra_reg) | (~|rb_reg) | (~borrow_ab & ~|diff_ab);
    assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + ITER_W'(1);

    always_comb begin
        state_next  = state_reg;
        ra_next     = ra_reg;
        rb_next     = rb_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        iters_next  = iters_reg;
        err_next    = err_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    ra_next    = a_in;
                    rb_next    = b_in;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (stop_cond) begin
                    state_next = FINISH;
                end else if (!borrow_ab) begin
                    ra_next  = diff_ab;
                    cnt_next = cnt_inc;
                end else begin
                    // borrow_ba is necessarily clear here since rb > ra
                    rb_next  = diff_ba;
                    cnt_next = cnt_inc;
                end
            end
            FINISH: begin
                result_next = ra_reg | rb_reg;
                err_next    = (~|ra_reg) & (~|rb_reg);
                iters_next  = cnt_reg;
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            ra_reg     <= '0;
            rb_reg     <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            iters_reg  <= '0;
            err_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ra_reg     <= ra_next;
            rb_reg     <= rb_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            iters_reg  <= iters_next;
            err_reg    <= err_next;
            done_reg   <= done_next;
        end
    end

    assign busy   = (state_reg == COMPUTE);
    assign done   = done_reg;
    assign result = result_reg;
    assign iters  = iters_reg;
    assign err    = err_reg;

    // borrow_ba only mirrors borrow_ab; kept so both subtractors are structurally identical
    logic unused_ok;
    assign unused_ok = borrow_ba;
endmodule

// File: tb/tb_gcd_sub_engine.sv
// Self-checking bench for gcd_sub_engine: directed scenarios on 8- and 4-bit instances plus
// randomized 8-bit operations checked against an Euclid-quotient reference model.
module tb_gcd_sub_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, start8, busy8, done8, err8;
    logic [7:0] a8, b8, res8, it8;
    logic       rst4, start4, busy4, done4, err4;
    logic [3:0] a4, b4, res4, it4;

    int tests_run    = 0;
    int tests_failed = 0;

    gcd_sub_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .result(res8), .iters(it8), .err(err8)
    );

    gcd_sub_engine #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a_in(a4), .b_in(b4),
        .busy(busy4), .done(done4), .result(res4), .iters(it4), .err(err4)
    );

    // Reference: gcd via modulo Euclid.
    function automatic int ref_gcd(int a, int b);
        int t;
        if (a == 0) return b;
        if (b == 0) return a;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtraction count = sum of Euclid quotients minus one (stop at equality, not at zero).
    function automatic int ref_subs(int a, int b);
        int n, t;
        if (a == 0 || b == 0) return 0;
        n = 0;
        while (b != 0) begin
            n += a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return n - 1;
    endfunction

    // Issue one op on dut8 from a settled point, wait (bounded) for done; edges counts the accept edge as 1.
    task automatic op8(input int a, input int b, output int edges, output int busy_cycles);
        a8 = 8'(a); b8 = 8'(b); start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 1;
        busy_cycles = 0;
        while (!done8 && edges < 600) begin
            if (busy8) busy_cycles++;
            @(posedge clk); #1;
            edges++;
        end
        $display("[TB] w8 a=%0d b=%0d -> result=%0d iters=%0d err=%0b done=%0b edges=%0d",
                 a, b, res8, it8, err8, done8, edges);
    endtask

    task automatic op4(input int a, input int b, output int edges);
        a4 = 4'(a); b4 = 4'(b); start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        edges = 1;
        while (!done4 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        $display("[TB] w4 a=%0d b=%0d -> result=%0d iters=%0d err=%0b done=%0b edges=%0d",
                 a, b, res4, it4, err4, done4, edges);
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst4 = 1'b1; start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst8 = 1'b0; rst4 = 1'b0;
        tests_run++;
        if ({busy8, done8, err8, res8, it8} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset8: busy/done/err/result/iters=%b required all zero", {busy8, done8, err8, res8, it8});
        end
        tests_run++;
        if ({busy4, done4, err4, res4, it4} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset4: busy/done/err/result/iters=%b required all zero", {busy4, done4, err4, res4, it4});
        end
    endtask

    task automatic test_basic();
        int e, bc;
        op8(12, 8, e, bc);
        tests_run++;
        if (done8 !== 1'b1 || e != 5) begin
            tests_failed++;
            $display("FAIL basic_latency: done=%b edges=%0d required done=1 edges=5", done8, e);
        end
        tests_run++;
        if (res8 !== 8'd4 || it8 !== 8'd2 || err8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: result=%0d iters=%0d err=%b required 4 2 0", res8, it8, err8);
        end
        tests_run++;
        if (bc != 3) begin
            tests_failed++;
            $display("FAIL basic_busy: busy cycles=%0d required 3", bc);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done8 !== 1'b0 || res8 !== 8'd4) begin
            tests_failed++;
            $display("FAIL basic_pulse: done=%b result=%0d required done=0 result held 4", done8, res8);
        end
    endtask

    task automatic test_width4();
        int e;
        op4(15, 1, e);
        tests_run++;
        if (done4 !== 1'b1 || res4 !== 4'd1 || it4 !== 4'd14 || err4 !== 1'b0 || e != 17) begin
            tests_failed++;
            $display("FAIL w4_15_1: done=%b result=%0d iters=%0d err=%b edges=%0d required 1 1 14 0 17",
                     done4, res4, it4, err4, e);
        end
        op4(0, 9, e);
        tests_run++;
        if (done4 !== 1'b1 || res4 !== 4'd9 || it4 !== 4'd0 || err4 !== 1'b0 || e != 3) begin
            tests_failed++;
            $display("FAIL w4_0_9: done=%b result=%0d iters=%0d err=%b edges=%0d required 1 9 0 0 3",
                     done4, res4, it4, err4, e);
        end
        op4(0, 0, e);
        tests_run++;
        if (done4 !== 1'b1 || res4 !== 4'd0 || it4 !== 4'd0 || err4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL w4_0_0: done=%b result=%0d iters=%0d err=%b required 1 0 0 1", done4, res4, it4, err4);
        end
        @(posedge clk); #1;
        tests_run++;
        if (err4 !== 1'b1 || done4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL w4_err_hold: err=%b done=%b required err=1 done=0", err4, done4);
        end
    endtask

    task automatic test_boundary();
        int e, bc;
        op8(200, 200, e, bc);
        tests_run++;
        if (done8 !== 1'b1 || res8 !== 8'd200 || it8 !== 8'd0 || e != 3) begin
            tests_failed++;
            $display("FAIL equal_ops: done=%b result=%0d iters=%0d edges=%0d required 1 200 0 3", done8, res8, it8, e);
        end
        op8(255, 254, e, bc);
        tests_run++;
        if (done8 !== 1'b1 || res8 !== 8'd1 || it8 !== 8'd254 || e != 257) begin
            tests_failed++;
            $display("FAIL long_ops: done=%b result=%0d iters=%0d edges=%0d required 1 1 254 257", done8, res8, it8, e);
        end
    endtask

    task automatic test_reset_mid();
        int e, bc;
        bit saw_done;
        a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        tests_run++;
        if (busy8 !== 1'b0 || res8 !== 8'd0 || done8 !== 1'b0 || it8 !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b result=%0d done=%b iters=%0d required 0 0 0 0", busy8, res8, done8, it8);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet: activity after abandoned op=1 required 0");
        end
        op8(9, 6, e, bc);
        tests_run++;
        if (done8 !== 1'b1 || res8 !== 8'd3 || it8 !== 8'd2 || e != 5) begin
            tests_failed++;
            $display("FAIL reset_mid_restart: done=%b result=%0d iters=%0d edges=%0d required 1 3 2 5", done8, res8, it8, e);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        a8 = 8'd20; b8 = 8'd6; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd9; b8 = 8'd3;   // start stays high; these must not disturb the running op
        e = 1;
        while (!done8 && e < 600) begin
            @(posedge clk); #1;
            e++;
        end
        $display("[TB] w8 held-start a=20 b=6 -> result=%0d iters=%0d done=%0b edges=%0d", res8, it8, done8, e);
        tests_run++;
        if (done8 !== 1'b1 || res8 !== 8'd2 || it8 !== 8'd5 || e != 8) begin
            tests_failed++;
            $display("FAIL b2b_first: done=%b result=%0d iters=%0d edges=%0d required 1 2 5 8", done8, res8, it8, e);
        end
        @(posedge clk); #1;
        start8 = 1'b0;
        tests_run++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept: busy=%b done=%b required busy=1 done=0", busy8, done8);
        end
        e = 1;
        while (!done8 && e < 600) begin
            @(posedge clk); #1;
            e++;
        end
        $display("[TB] w8 back-to-back a=9 b=3 -> result=%0d iters=%0d done=%0b edges=%0d", res8, it8, done8, e);
        tests_run++;
        if (done8 !== 1'b1 || res8 !== 8'd3 || it8 !== 8'd2 || e != 5) begin
            tests_failed++;
            $display("FAIL b2b_second: done=%b result=%0d iters=%0d edges=%0d required 1 3 2 5", done8, res8, it8, e);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: done=%b busy=%b required 0 0", done8, busy8);
        end
    endtask

    task automatic test_random();
        int a, b, eg, es, e, bc;
        for (int n = 0; n < 1000; n++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            eg = ref_gcd(a, b);
            es = ref_subs(a, b);
            op8(a, b, e, bc);
            tests_run++;
            if (done8 !== 1'b1 || res8 !== 8'(eg) || it8 !== 8'(es) || err8 !== ((a == 0 && b == 0) ? 1'b1 : 1'b0)) begin
                tests_failed++;
                $display("FAIL rand_result a=%0d b=%0d: done=%b result=%0d iters=%0d err=%b required 1 %0d %0d %0b",
                         a, b, done8, res8, it8, err8, eg, es, (a == 0 && b == 0));
            end
            tests_run++;
            if (e != es + 3) begin
                tests_failed++;
                $display("FAIL rand_latency a=%0d b=%0d: edges=%0d required %0d", a, b, e, es + 3);
            end
            @(posedge clk); #1;
            tests_run++;
            if (done8 !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_pulse a=%0d b=%0d: done second cycle=%b required 0", a, b, done8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_width4();
        test_boundary();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
